// File: rtl/vga_pkg.sv
// Shared constants, types and the pixel address helper for the frame-buffer sink.
// No ports. Imported by vga_fb_sink_if, fb_ram and vga_fb_sink.
package vga_pkg;

  localparam int H_PIX     = 160;
  localparam int V_PIX     = 120;
  localparam int COLOUR_W  = 3;
  localparam int FB_DEPTH  = H_PIX * V_PIX;
  localparam int FB_ADDR_W = 15;

  typedef logic [COLOUR_W-1:0]  colour_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } fb_state_t;

  // Row-major address. Only called for on-screen coordinates, so the
  // result always lies below FB_DEPTH.
  function automatic fb_addr_t pix_addr(input logic [7:0] x, input logic [6:0] y);
    return fb_addr_t'(y) * fb_addr_t'(H_PIX) + fb_addr_t'(x);
  endfunction

endpackage

// File: rtl/vga_fb_sink_if.sv
// Plot strobe bundle between the drawing engines and the frame-buffer sink.
// Signals:
//   vga_x      plot column (8 bits)
//   vga_y      plot row (7 bits)
//   vga_colour plot colour
//   vga_plot   write strobe, one pixel per cycle while high
// Modports: master (drawing engine side), slave (frame-buffer sink side).
interface vga_fb_sink_if;
  import vga_pkg::*;

  logic [7:0] vga_x;
  logic [6:0] vga_y;
  colour_t    vga_colour;
  logic       vga_plot;

  modport master (output vga_x, vga_y, vga_colour, vga_plot);
  modport slave  (input  vga_x, vga_y, vga_colour, vga_plot);

endinterface

// File: rtl/fb_ram.sv
// 160x120x3 frame memory: one write port, one registered read port.
// Ports:
//   clk      clock
//   wr_en    write enable
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read enable (updates rd_data)
//   rd_addr  read address
//   rd_data  registered read data; returns the contents before any write
//            to the same address on the same edge
// Contents are deliberately not reset so the array maps onto block RAM.
module fb_ram
  import vga_pkg::*;
(
  input  logic     clk,
  input  logic     wr_en,
  input  fb_addr_t wr_addr,
  input  colour_t  wr_data,
  input  logic     rd_en,
  input  fb_addr_t rd_addr,
  output colour_t  rd_data
);

  colour_t mem [FB_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/vga_fb_sink.sv
// Pixel sink for the drawing engines: writes plots into the frame memory,
// drops off-screen plots, runs a start/done screen clear, and scans the
// frame back out in raster order.
// Build option: CLIP_COUNT_EN enables the saturating clipped-plot counter;
// without it clip_count is tied to zero.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   plot            plot strobe bundle (vga_x, vga_y, vga_colour, vga_plot)
//   clear_start     level request to fill the screen
//   clear_colour    fill colour, captured when the clear starts
//   clear_done      clear finished; held until clear_start drops
//   busy            clear in progress
//   scan_en         advance the raster readout
//   scan_x, scan_y  coordinate of scan_colour
//   scan_colour     pixel read from memory (0 while scan_valid is low)
//   scan_valid      scan outputs valid
//   frame_start     marks the pixel at (0,0)
//   clip_count      number of clipped plots
//
// state | meaning
// IDLE  | plots accepted, waiting for clear_start
// CLEAR | filling memory with the captured colour, plots dropped
// DONE  | clear finished, plots accepted, waiting for clear_start to drop
module vga_fb_sink
  import vga_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  vga_fb_sink_if.slave        plot,
  input  logic                clear_start,
  input  colour_t             clear_colour,
  output logic                clear_done,
  output logic                busy,
  input  logic                scan_en,
  output logic [7:0]          scan_x,
  output logic [6:0]          scan_y,
  output colour_t             scan_colour,
  output logic                scan_valid,
  output logic                frame_start,
  output logic [15:0]         clip_count
);

  fb_state_t state, state_nxt;
  fb_addr_t  clr_addr;
  colour_t   clr_colour;
  logic      clr_last;

  logic       on_screen;
  logic       plot_ok;
  logic       plot_wr;

  logic [7:0] sx;
  logic [6:0] sy;
  colour_t    rd_data;

  logic       wr_en;
  fb_addr_t   wr_addr;
  colour_t    wr_data;

  assign clr_last = (clr_addr == fb_addr_t'(FB_DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    clear_done = 1'b0;
    case (state)
      IDLE: begin
        if (clear_start) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        busy = 1'b1;
        if (clr_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        clear_done = 1'b1;
        if (!clear_start) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr   <= '0;
      clr_colour <= '0;
    end else if (state == IDLE && clear_start) begin
      clr_addr   <= '0;
      clr_colour <= clear_colour;
    end else if (state == CLEAR) begin
      clr_addr   <= clr_addr + fb_addr_t'(1);
    end
  end

  // The clear owns the write port; plots arriving during it vanish.
  assign on_screen = (plot.vga_x < 8'(H_PIX)) && (plot.vga_y < 7'(V_PIX));
  assign plot_ok   = plot.vga_plot && (state != CLEAR);
  assign plot_wr   = plot_ok && on_screen;

  assign wr_en   = busy || plot_wr;
  assign wr_addr = busy ? clr_addr   : pix_addr(plot.vga_x, plot.vga_y);
  assign wr_data = busy ? clr_colour : plot.vga_colour;

  fb_ram u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (scan_en),
    .rd_addr (pix_addr(sx, sy)),
    .rd_data (rd_data)
  );

  // Raster counters address the RAM; the registered copies line up with
  // the RAM's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx          <= '0;
      sy          <= '0;
      scan_x      <= '0;
      scan_y      <= '0;
      scan_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      scan_valid  <= scan_en;
      frame_start <= scan_en && (sx == '0) && (sy == '0);
      if (scan_en) begin
        scan_x <= sx;
        scan_y <= sy;
        if (sx == 8'(H_PIX - 1)) begin
          sx <= '0;
          sy <= (sy == 7'(V_PIX - 1)) ? '0 : sy + 7'd1;
        end else begin
          sx <= sx + 8'd1;
        end
      end
    end
  end

  // RAM output has no reset; gating keeps scan_colour at 0 out of reset.
  assign scan_colour = scan_valid ? rd_data : '0;

`ifdef CLIP_COUNT_EN
  logic        plot_clip;
  logic [15:0] clip_cnt;

  assign plot_clip = plot_ok && !on_screen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_cnt <= '0;
    end else if (plot_clip && clip_cnt != 16'hFFFF) begin
      clip_cnt <= clip_cnt + 16'd1;
    end
  end

  assign clip_count = clip_cnt;
`else
  assign clip_count = '0;
`endif

endmodule

// File: tb/tb_vga_fb_sink.sv
// Randomized self-checking bench for vga_fb_sink. A frame image array plus
// a raster position stands in for the design; plots are applied to the
// image after the pixel being scanned on the same cycle has been sampled.
module tb_vga_fb_sink;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_start = 1'b0;
  colour_t     clear_colour = '0;
  logic        clear_done;
  logic        busy;
  logic        scan_en = 1'b0;
  logic [7:0]  scan_x;
  logic [6:0]  scan_y;
  colour_t     scan_colour;
  logic        scan_valid;
  logic        frame_start;
  logic [15:0] clip_count;

  vga_fb_sink_if plot_if();

  vga_fb_sink dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .plot         (plot_if),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .clear_done   (clear_done),
    .busy         (busy),
    .scan_en      (scan_en),
    .scan_x       (scan_x),
    .scan_y       (scan_y),
    .scan_colour  (scan_colour),
    .scan_valid   (scan_valid),
    .frame_start  (frame_start),
    .clip_count   (clip_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  colour_t fb_model [FB_DEPTH];
  colour_t img      [FB_DEPTH];
  int msx, msy, clip_model;
  int scan_err, valid_cnt, fs_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_clip();
`ifdef CLIP_COUNT_EN
    return (clip_model > 65535) ? 65535 : clip_model;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_plot(input int x, input int y, input int c, input logic p);
    plot_if.vga_x      = 8'(x);
    plot_if.vga_y      = 7'(y);
    plot_if.vga_colour = 3'(c);
    plot_if.vga_plot   = p;
  endtask

  task automatic fill_model(input colour_t c);
    for (int i = 0; i < FB_DEPTH; i++) fb_model[i] = c;
  endtask

  // One clock with the currently driven plot/scan_en, outside of a clear.
  task automatic step_model();
    logic    exp_v, exp_fs;
    int      ex, ey, px, py;
    colour_t ec;
    exp_v  = scan_en;
    exp_fs = 1'b0;
    ex = 0; ey = 0; ec = '0;
    if (scan_en) begin
      ex = msx; ey = msy;
      ec = fb_model[msy * H_PIX + msx];
      exp_fs = (msx == 0 && msy == 0);
      msx++;
      if (msx == H_PIX) begin
        msx = 0;
        msy = (msy + 1) % V_PIX;
      end
    end
    if (plot_if.vga_plot) begin
      px = int'(plot_if.vga_x);
      py = int'(plot_if.vga_y);
      if (px < H_PIX && py < V_PIX) fb_model[py * H_PIX + px] = plot_if.vga_colour;
      else clip_model++;
    end
    tick();
    if (scan_valid !== exp_v || frame_start !== exp_fs) scan_err++;
    else if (exp_v && (scan_x !== 8'(ex) || scan_y !== 7'(ey) || scan_colour !== ec)) scan_err++;
    if (exp_v) begin
      img[ey * H_PIX + ex] = scan_colour;
      valid_cnt++;
      if (frame_start) fs_cnt++;
    end
  endtask

  // Starts a clear and returns the number of cycles busy was seen high.
  task automatic run_clear(input colour_t c, input logic with_plots, output int n);
    clear_colour = c;
    clear_start  = 1'b1;
    tick();
    check_val("busy_rise", busy, 1);
    clear_colour = ~c;
    n = busy ? 1 : 0;
    for (int k = 0; k < 20000 && !clear_done; k++) begin
      if (with_plots && n == 10000) set_plot(5, 5, 7, 1'b1);
      else if (with_plots && n == 10001) set_plot(200, 5, 2, 1'b1);
      else plot_if.vga_plot = 1'b0;
      tick();
      if (busy) n++;
    end
    plot_if.vga_plot = 1'b0;
  endtask

  initial begin
    int n, cyc, held_err, px, py;
    colour_t c2, c3;

    set_plot(0, 0, 0, 1'b0);
    msx = 0; msy = 0; clip_model = 0;

    tick();
    tick();
    check_val("rst_busy", busy, 0);
    check_val("rst_done", clear_done, 0);
    check_val("rst_valid", scan_valid, 0);
    check_val("rst_fstart", frame_start, 0);
    check_val("rst_scan_xy", {scan_x, scan_y}, 0);
    check_val("rst_colour", scan_colour, 0);
    check_val("rst_clip", clip_count, 0);
    rst_n = 1'b1;
    tick();

    // First clear with plots landing mid-clear
    run_clear(3'b001, 1'b1, n);
    check_val("clear_len", n, FB_DEPTH);
    check_val("clear_done_set", clear_done, 1);
    check_val("clip_during_clear", clip_count, 0);
    fill_model(3'b001);

    held_err = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (busy || !clear_done) held_err++;
    end
    check_val("done_held", held_err, 0);
    clear_start = 1'b0;
    #1;
    check_val("clear_done_hold", clear_done, 1);
    tick();
    check_val("clear_done_drop", clear_done, 0);

    // Directed plots including circle-edge clipping
    set_plot(10, 20, 5, 1'b1);   step_model();
    set_plot(160, 117, 3, 1'b1); step_model();
    set_plot(157, 117, 6, 1'b1); step_model();
    set_plot(154, 117, 2, 1'b1); step_model();
    for (int k = 0; k < 8; k++) begin
      set_plot($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7), 1'b0);
      step_model();
    end
    check_val("clip_after_plots", clip_count, exp_clip());

    // Full frame plus wrap with random scan gaps and random plots
    valid_cnt = 0; fs_cnt = 0; scan_err = 0; cyc = 0;
    while (valid_cnt < FB_DEPTH + 10 && cyc < 40000) begin
      scan_en = ($urandom % 4 != 0);
      if (scan_en && valid_cnt == 3) begin
        set_plot(msx, msy, int'(~fb_model[msy * H_PIX + msx]), 1'b1);
      end else if ($urandom % 3 == 0) begin
        px = $urandom_range(0, 175);
        py = ($urandom % 4 == 0) ? $urandom_range(120, 127) : $urandom_range(30, 100);
        set_plot(px, py, $urandom_range(0, 7), 1'b1);
      end else begin
        set_plot($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7), 1'b0);
      end
      step_model();
      cyc++;
    end
    scan_en = 1'b0;
    plot_if.vga_plot = 1'b0;
    check_val("scan_budget", valid_cnt, FB_DEPTH + 10);
    check_val("scan_err", scan_err, 0);
    check_val("frame_pulses", fs_cnt, 2);
    check_val("pix_10_20", img[20 * H_PIX + 10], 3'b101);
    check_val("pix_9_20", img[20 * H_PIX + 9], 3'b001);
    check_val("pix_11_20", img[20 * H_PIX + 11], 3'b001);
    check_val("pix_157_117", img[117 * H_PIX + 157], 3'b110);
    check_val("pix_154_117", img[117 * H_PIX + 154], 3'b010);
    check_val("pix_0_118", img[118 * H_PIX], 3'b001);
    check_val("pix_5_5", img[5 * H_PIX + 5], 3'b001);
    check_val("clip_after_scan", clip_count, exp_clip());

    // Reset in the middle of a clear
    c2 = 3'($urandom_range(0, 7));
    c3 = c2 ^ 3'b101;
    clear_colour = c2;
    clear_start  = 1'b1;
    tick();
    check_val("busy_rise_2", busy, 1);
    for (int k = 1; k < 5000; k++) tick();
    rst_n = 1'b0;
    #1;
    check_val("async_rst_busy", busy, 0);
    check_val("async_rst_done", clear_done, 0);
    clear_start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_val("post_rst_busy", busy, 0);
    check_val("post_rst_valid", scan_valid, 0);
    check_val("post_rst_clip", clip_count, 0);
    msx = 0; msy = 0; clip_model = 0;

    run_clear(c3, 1'b0, n);
    check_val("clear2_len", n, FB_DEPTH);
    check_val("clear2_done", clear_done, 1);
    fill_model(c3);
    clear_start = 1'b0;
    tick();
    check_val("clear2_drop", clear_done, 0);

    valid_cnt = 0; fs_cnt = 0; scan_err = 0;
    scan_en = 1'b1;
    for (int k = 0; k < 400; k++) step_model();
    scan_en = 1'b0;
    check_val("scan2_err", scan_err, 0);
    check_val("scan2_fstart", fs_cnt, 1);
    check_val("scan2_pix399", img[399], c3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_fb_sink.md
Name: vga_fb_sink

Overview:
- Pixel sink at the far end of the plot interface driven by the drawing engines (circle, line, fill).
- Accepts vga_x/vga_y/vga_colour/vga_plot write strobes into an on-chip 160x120x3 frame memory.
- Drops off-screen coordinates; provides a start/done screen-clear engine.
- Continuously reads the frame back in raster order for the display/compare path.

Parameters:
- H_PIX, 160, visible columns.
- V_PIX, 120, visible rows.
- COLOUR_W, 3, bits per pixel.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- vga_x  in  8  plot column
- vga_y  in  7  plot row
- vga_colour  in  COLOUR_W  plot colour
- vga_plot  in  1  write strobe, one pixel per cycle while high
- clear_start  in  1  level request to fill the screen
- clear_colour  in  COLOUR_W  fill colour, sampled on entry to CLEAR
- clear_done  out  1  clear complete; held until clear_start drops
- busy  out  1  high in CLEAR
- scan_en  in  1  advance raster readout
- scan_x  out  8  column of scan_colour
- scan_y  out  7  row of scan_colour
- scan_colour  out  COLOUR_W  pixel read from memory
- scan_valid  out  1  scan_x/scan_y/scan_colour valid
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- clip_count  out  16  clipped-plot counter (see Optional Feature)

Behaviour:
- Clock/reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; scan counters at (0,0). Memory contents are not initialised by reset.
- Address: addr = y*H_PIX + x, 15 bits, computed combinationally.
- FSM transitions:
  - IDLE -> CLEAR when clear_start=1. Latch clear_colour; clear counter = 0.
  - CLEAR: write clear_colour at counter, one address per cycle, 0..H_PIX*V_PIX-1 (19200 cycles). After the last write -> DONE.
  - DONE: clear_done=1. When clear_start=0, go to IDLE; clear_done drops the cycle after.
  - clear_start held through DONE never retriggers a clear.
- Plot writes:
  - In IDLE or DONE with vga_plot=1: if vga_x<H_PIX and vga_y<V_PIX, write vga_colour at addr in the same clock edge.
  - Otherwise the plot is clipped: no write; clip counter +1.
  - vga_plot=0 leaves memory unchanged regardless of x/y/colour.
- Plot during CLEAR: dropped silently, not counted as clipped. The clear has exclusive write access.
- Scanout:
  - Raster counters advance only when scan_en=1: x 0..H_PIX-1, then wrap to 0 and y+1; y wraps V_PIX-1 -> 0.
  - Memory read is registered. scan_colour/scan_x/scan_y/scan_valid lag the counters by exactly 1 cycle; scan_valid = scan_en delayed 1 cycle.
  - frame_start = 1 with the scan_valid cycle carrying (0,0).
- Same-address read/write in one cycle: scan returns the old data (read-before-write). The new value is visible on the next pass.
- Reset mid-CLEAR: immediate return to IDLE; clear_done=0, busy=0. Memory is partially cleared; that is permitted.

Optional Feature:
- CLIP_COUNT_EN defined: clip_count is a 16-bit saturating counter (stops at 16'hFFFF), incremented per clipped plot, reset to 0 by rst_n only.
- Not defined: clip_count is tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package vga_pkg holds:
  - constants H_PIX, V_PIX, COLOUR_W, FB_DEPTH=19200, FB_ADDR_W=15;
  - typedef colour_t (logic [2:0]);
  - typedef enum fb_state_t {IDLE, CLEAR, DONE}.
- Sub-module fb_ram: single-write, registered-read dual-port memory, read-before-write, so synthesis infers block RAM. FSM, clipping and scan counters stay in vga_fb_sink.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> all outputs 0, scan_valid=0, busy=0.
- Clear handshake:
  - Stimulus: clear_start=1 with clear_colour=3'b001.
  - busy=1 the next cycle; clear_done=1 after 19200 CLEAR cycles.
  - Hold clear_start 10 more cycles -> clear_done stays 1 with no re-clear.
  - Drop clear_start -> clear_done=0 one cycle later.
- Plot and readback:
  - Stimulus: after clear, plot (10,20,3'b101); run a full frame with scan_en=1.
  - scan at (10,20) = 3'b101; (9,20) and (11,20) = 3'b001.
  - frame_start pulses once per 19200 valid pixels.
- Clipping:
  - Stimulus: plot circle-edge points (160,117), (157,117), (154,117).
  - Only (157,117) and (154,117) are written.
  - clip_count = 1 with CLIP_COUNT_EN; 0 without.
- Plot during clear:
  - Stimulus: vga_plot=1 at (5,5,3'b111) while busy=1.
  - After clear, (5,5) reads clear_colour; clip_count unchanged.
- Reset mid-clear:
  - Stimulus: assert rst_n=0 at CLEAR cycle 5000.
  - busy and clear_done go 0 asynchronously; FSM in IDLE.
  - A subsequent clear completes normally in 19200 cycles.
